// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory read at a time,
// handles branch/return redirects and decode stalls, and tracks the link register.
module fetch_stage #(
  parameter logic [7:0] RST_PC  = 8'h00,
  parameter logic [7:0] NOP_INS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] pc_sel,
  input  logic [7:0] br_target,
  input  logic       lr_we,
  input  logic       pc_en,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] if_ins,
  output logic [7:0] if_pc,
  output logic       if_valid,
  output logic [7:0] lr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0] state;
  logic [7:0] pc;
  logic [7:0] req_addr;
  logic [7:0] hold_ins;
  logic       redirect;
  logic [7:0] target;

  // pc_sel=11 is reserved and behaves as sequential; a return reads lr before any same-cycle write
  always_comb begin
    redirect = (pc_sel == 2'b01) || (pc_sel == 2'b10);
    target   = (pc_sel == 2'b01) ? br_target : lr;
  end

  // DRAIN keeps the stale request visible until its ack retires it
  assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign imem_addr = req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RST_PC;
      req_addr <= RST_PC;
      lr       <= 8'h00;
      hold_ins <= NOP_INS;
      if_ins   <= NOP_INS;
      if_pc    <= 8'h00;
      if_valid <= 1'b0;
    end else begin
      if (lr_we)
        lr <= if_pc + 8'd1;

      if (redirect) begin
        if_valid <= 1'b0;
        if_ins   <= NOP_INS;
        pc       <= target;
      end

      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          req_addr <= redirect ? target : pc;
        end

        S_REQ: begin
          if (redirect) begin
            if (imem_ack)
              req_addr <= target;
            else
              state <= S_DRAIN;
          end else if (imem_ack) begin
            if (pc_en) begin
              if_ins   <= imem_data;
              if_pc    <= req_addr;
              if_valid <= 1'b1;
              pc       <= req_addr + 8'd1;
              req_addr <= req_addr + 8'd1;
            end else begin
              hold_ins <= imem_data;
              state    <= S_HOLD;
            end
          end else if (pc_en) begin
            if_valid <= 1'b0;
            if_ins   <= NOP_INS;
          end
        end

        // The outstanding word belongs to an abandoned path; only its ack matters
        S_DRAIN: begin
          if (imem_ack) begin
            req_addr <= redirect ? target : pc;
            state    <= S_REQ;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            req_addr <= target;
            state    <= S_REQ;
          end else if (pc_en) begin
            if_ins   <= hold_ins;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + 8'd1;
            req_addr <= pc + 8'd1;
            state    <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a variable-latency memory plus a flight/park reference
// model of the fetch contract, driven by directed scenarios and random traffic.
module tb_fetch_stage;

  localparam logic [7:0] RST_PC  = 8'h00;
  localparam logic [7:0] NOP_INS = 8'hEE;

  logic       clk;
  logic       rst;
  logic [1:0] pc_sel;
  logic [7:0] br_target;
  logic       lr_we;
  logic       pc_en;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] if_ins;
  logic [7:0] if_pc;
  logic       if_valid;
  logic [7:0] lr;

  fetch_stage #(.RST_PC(RST_PC), .NOP_INS(NOP_INS)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .br_target(br_target),
    .lr_we(lr_we), .pc_en(pc_en), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .if_ins(if_ins), .if_pc(if_pc),
    .if_valid(if_valid), .lr(lr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory side
  logic [7:0] mem [256];
  bit         mem_busy;
  logic [7:0] mem_addr;
  int         mem_cnt;
  int         lat;
  bit         rand_lat;
  bit         spurious;

  // reference model: next address to deliver, the fetch in flight, a parked word
  logic [7:0] m_pc, m_fetch, m_ins, m_ipc, m_lr, m_park;
  bit         m_idle, m_wait, m_squash, m_parked, m_valid;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_req", {7'b0, imem_req}, {7'b0, m_wait});
    checkOutput("imem_addr", imem_addr, m_fetch);
    checkOutput("if_valid", {7'b0, if_valid}, {7'b0, m_valid});
    checkOutput("if_ins", if_ins, m_ins);
    checkOutput("if_pc", if_pc, m_ipc);
    checkOutput("lr", lr, m_lr);
  endtask

  task automatic modelReset();
    m_pc = RST_PC; m_fetch = RST_PC; m_lr = 8'h00; m_ins = NOP_INS; m_ipc = 8'h00;
    m_park = NOP_INS; m_valid = 0; m_idle = 1; m_wait = 0; m_squash = 0; m_parked = 0;
  endtask

  task automatic modelEdge(input logic [1:0] sel, input logic [7:0] tgt, input bit lrwe,
                           input bit en, input bit ack, input logic [7:0] data);
    bit         redir;
    logic [7:0] dest;
    logic [7:0] next_lr;
    redir   = (sel == 2'b01) || (sel == 2'b10);
    dest    = (sel == 2'b01) ? tgt : m_lr;
    next_lr = lrwe ? m_ipc + 8'd1 : m_lr;
    if (redir) begin
      m_pc = dest; m_valid = 0; m_ins = NOP_INS;
    end
    if (m_idle) begin
      m_idle = 0; m_wait = 1; m_fetch = m_pc;
    end else if (m_parked) begin
      if (redir) begin
        m_parked = 0; m_wait = 1; m_fetch = dest;
      end else if (en) begin
        m_ins = m_park; m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 8'd1; m_fetch = m_pc; m_parked = 0; m_wait = 1;
      end
    end else if (m_squash) begin
      if (ack) begin
        m_squash = 0; m_fetch = m_pc;
      end
    end else if (redir) begin
      if (ack) m_fetch = dest;
      else     m_squash = 1;
    end else if (ack) begin
      if (en) begin
        m_ins = data; m_ipc = m_fetch; m_valid = 1;
        m_fetch = m_fetch + 8'd1; m_pc = m_fetch;
      end else begin
        m_parked = 1; m_park = data; m_wait = 0;
      end
    end else if (en) begin
      m_valid = 0; m_ins = NOP_INS;
    end
    m_lr = next_lr;
  endtask

  // One clock: memory responds, inputs applied, model advanced, outputs checked at negedge
  task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] tgt,
                               input bit lrwe, input bit en);
    bit         a;
    logic [7:0] d;
    a = 0;
    d = 8'($urandom);
    if (spurious) begin
      a = 1;
      spurious = 0;
    end else begin
      if (mem_busy) begin
        checkOutput("addr_stable", imem_addr, mem_addr);
        checkOutput("req_held", {7'b0, imem_req}, 8'h01);
      end else if (imem_req) begin
        mem_busy = 1;
        mem_addr = imem_addr;
        mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          a = 1; d = mem[mem_addr]; mem_busy = 0;
        end
      end
    end
    pc_sel = sel; br_target = tgt; lr_we = lrwe; pc_en = en;
    imem_ack = a; imem_data = d;
    modelEdge(sel, tgt, lrwe, en, a, d);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  // Reset with a stray ack during reset and in the first idle cycle
  task automatic doReset();
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_data = 8'($urandom);
    #1;
    modelReset();
    mem_busy = 0;
    checkAll();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    rst = 1'b0;
    spurious = 1;
  endtask

  initial begin
    logic [1:0] sel;
    int         r;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    lat = 1; rand_lat = 0; spurious = 0; mem_busy = 0; mem_cnt = 0; mem_addr = 8'h00;
    rst = 1'b1; pc_sel = 2'b00; br_target = 8'h00; lr_we = 1'b0; pc_en = 1'b1;
    imem_ack = 1'b0; imem_data = 8'h00;
    modelReset();
    @(negedge clk);
    doReset();
    checkOutput("idle_req", {7'b0, imem_req}, 8'h00);

    // zero-wait sequential fetch
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("first_addr", imem_addr, RST_PC);
    checkOutput("first_req", {7'b0, imem_req}, 8'h01);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("seq_if_pc", if_pc, 8'h04);
    checkOutput("seq_valid", {7'b0, if_valid}, 8'h01);

    // branch while request for 05 is outstanding at latency 3
    lat = 3;
    applyStimulus(2'b00, 8'h00, 0, 1);
    applyStimulus(2'b01, 8'h40, 0, 1);
    checkOutput("drain_addr", imem_addr, 8'h05);
    checkOutput("drain_valid", {7'b0, if_valid}, 8'h00);
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("br_addr", imem_addr, 8'h40);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 8'h00, 0, 1);
      checkOutput("br_bubble", {7'b0, if_valid}, 8'h00);
    end
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("br_if_pc", if_pc, 8'h40);
    checkOutput("br_if_ins", if_ins, mem[8'h40]);

    // stall on the ack of 10
    lat = 1;
    applyStimulus(2'b01, 8'h10, 0, 1);
    checkOutput("stall_addr", imem_addr, 8'h10);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 8'h00, 0, 0);
      checkOutput("stall_req", {7'b0, imem_req}, 8'h00);
      checkOutput("stall_if_pc", if_pc, 8'h40);
    end
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("resume_if_pc", if_pc, 8'h10);
    checkOutput("resume_ins", if_ins, mem[8'h10]);
    checkOutput("resume_addr", imem_addr, 8'h11);

    // link register and return
    applyStimulus(2'b01, 8'h20, 0, 1);
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("lr_if_pc", if_pc, 8'h20);
    applyStimulus(2'b00, 8'h00, 1, 1);
    checkOutput("lr_write", lr, 8'h21);
    applyStimulus(2'b10, 8'h00, 0, 1);
    checkOutput("ret_addr", imem_addr, 8'h21);
    applyStimulus(2'b10, 8'h00, 1, 1);
    checkOutput("ret_old_lr", imem_addr, 8'h21);
    checkOutput("lr_update", lr, 8'h22);

    // wrap from FF
    applyStimulus(2'b01, 8'hFF, 0, 1);
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("wrap_if_pc", if_pc, 8'hFF);
    checkOutput("wrap_addr", imem_addr, 8'h00);

    // reset while a fetch is outstanding
    lat = 3;
    applyStimulus(2'b00, 8'h00, 0, 1);
    doReset();
    checkOutput("rst_valid", {7'b0, if_valid}, 8'h00);
    applyStimulus(2'b00, 8'h00, 0, 1);
    checkOutput("rst_first_addr", imem_addr, RST_PC);
    checkOutput("rst_first_req", {7'b0, imem_req}, 8'h01);

    // random traffic with random latency
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      sel = (r < 8) ? 2'b01 : (r < 12) ? 2'b10 : (r < 15) ? 2'b11 : 2'b00;
      applyStimulus(sel, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0);
      if (i % 700 == 699) doReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RST_PC, 8'h00, PC value loaded on reset.
REQ-002 Parameter: NOP_INS, 8'h00, instruction word presented when no valid fetch is available.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pc_sel  in  2  redirect select: 00 sequential, 01 branch target, 10 return to link register, 11 reserved and treated as 00.
REQ-006 br_target  in  8  branch target address, used when pc_sel=01.
REQ-007 lr_we  in  1  link-register write enable.
REQ-008 pc_en  in  1  1 = advance, 0 = stall (bubble); fetch outputs frozen.
REQ-009 imem_req  out  1  instruction-memory read request.
REQ-010 imem_addr  out  8  instruction-memory read address.
REQ-011 imem_ack  in  1  read data valid, for exactly one cycle per request; latency 1..N cycles.
REQ-012 imem_data  in  8  instruction word, valid only when imem_ack=1.
REQ-013 if_ins  out  8  fetched instruction to decode; [7:4] opcode, [3:2] ra, [1:0] rb.
REQ-014 if_pc  out  8  address of if_ins.
REQ-015 if_valid  out  1  if_ins holds a real instruction.
REQ-016 lr  out  8  link register (return address).

Function
REQ-017 Registers: pc, req_addr, lr, hold_ins, state (IDLE, REQ, DRAIN, HOLD).
REQ-018 imem_addr SHALL equal req_addr; req_addr SHALL stay stable from request assertion through the ack cycle.
REQ-019 Redirect = pc_sel in {01,10}; target = br_target (01) or current lr (10).
REQ-020 IDLE: imem_req=0; next edge -> REQ, req_addr<=pc.
REQ-021 REQ, imem_req=1, no ack, no redirect: pc_en=1 -> if_valid<=0, if_ins<=NOP_INS; pc_en=0 -> outputs held.
REQ-022 REQ, ack, no redirect, pc_en=1: if_ins<=imem_data, if_pc<=req_addr, if_valid<=1, pc and req_addr <= req_addr+1 mod 256; stay REQ (back-to-back: request stays high).
REQ-023 REQ, ack, no redirect, pc_en=0: hold_ins<=imem_data, outputs held, imem_req<=0 -> HOLD.
REQ-024 HOLD, pc_en=1, no redirect: if_ins<=hold_ins, if_pc<=pc, if_valid<=1, pc and req_addr <= pc+1 -> REQ.
REQ-025 Redirect SHALL override pc_en=0 in all states: if_valid<=0, if_ins<=NOP_INS, pc<=target.
REQ-026 Redirect in REQ with ack same edge, or in HOLD or IDLE: data/hold_ins discarded, req_addr<=target -> REQ.
REQ-027 Redirect in REQ without ack: -> DRAIN; imem_req and req_addr unchanged.
REQ-028 DRAIN: on ack, data discarded, req_addr<=pc -> REQ; further redirects in DRAIN update pc only (last wins).
REQ-029 Exactly one fetch outstanding; no new request before the ack of the prior one.
REQ-030 lr_we=1: lr<=if_pc+1 mod 256; simultaneous pc_sel=10 uses pre-update lr.
REQ-031 PC wrap: 8'hFF+1 = 8'h00, no flag.

Reset
REQ-032 On rst: pc=req_addr=RST_PC, lr=8'h00, if_ins=hold_ins=NOP_INS, if_pc=8'h00, if_valid=0, imem_req=0, state IDLE, immediately and asynchronously.
REQ-033 rst mid-fetch abandons the request; an imem_ack arriving in reset or in the IDLE cycle after reset SHALL be ignored.
REQ-034 First request after reset release: imem_addr=RST_PC, one cycle after release.

Verification
REQ-035 Zero-wait memory (ack every cycle), pc_sel=00, pc_en=1 -> if_pc 00,01,02... on consecutive cycles, if_valid=1 after first ack.
REQ-036 Ack latency 3, pc_sel=01 br_target=8'h40 asserted one cycle after request at 8'h05 -> ack for 05 discarded, next imem_addr=8'h40, if_valid=0 until 40 returns.
REQ-037 pc_en=0 for 2 cycles on ack of 8'h10 -> if_ins/if_pc frozen, imem_req=0; on pc_en=1 if_pc=8'h10, next request 8'h11.
REQ-038 lr_we=1 with if_pc=8'h20, then pc_sel=10 -> next request imem_addr=8'h21; lr_we and pc_sel=10 same cycle -> old lr used.
REQ-039 pc=8'hFF sequential -> next imem_addr=8'h00.
REQ-040 rst asserted while waiting for ack, ack arrives during reset -> if_valid=0, first post-reset imem_addr=RST_PC.
